// File: rtl/inport_conditioner.sv
// Board-side producer for the host-visible inport word: synchronises raw switch/key pins,
// debounces each bit against a shared tick, normalises polarity and emits change strobes.
module inport_conditioner #(
    parameter int               WIDTH        = 16,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] INVERT_MASK  = 16'h000F
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] inport_word,
    output logic [WIDTH-1:0] rise_flags,
    output logic [WIDTH-1:0] fall_flags,
    output logic             change_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] norm;
    logic [PW-1:0]    presc;
    logic             tick;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] word_prev;

    // Stage p0/p1: two-flop synchroniser, idling at the released pin level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= INVERT_MASK;
            sync_p1 <= INVERT_MASK;
        end else begin
            sync_p0 <= raw_in;
            sync_p1 <= sync_p0;
        end
    end

    assign norm = sync_p1 ^ INVERT_MASK;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign tick = (presc == PRE_LAST);

    // A single cycle of agreement discards the accumulated count, so short glitches never commit
    always_comb begin
        word_next = inport_word;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (norm[i] == inport_word[i]) begin
                cnt_next[i] = '0;
            end else if (tick) begin
                if (cnt[i] == CNT_LAST) begin
                    word_next[i] = norm[i];
                    cnt_next[i]  = '0;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Stage p2: debounced word and per-bit counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inport_word <= '0;
            cnt         <= '{default: '0};
        end else begin
            inport_word <= word_next;
            cnt         <= cnt_next;
        end
    end

    // Stage p3: strobes compare the committed word with its previous value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_prev    <= '0;
            rise_flags   <= '0;
            fall_flags   <= '0;
            change_pulse <= 1'b0;
        end else begin
            word_prev    <= inport_word;
            rise_flags   <= inport_word & ~word_prev;
            fall_flags   <= ~inport_word & word_prev;
            change_pulse <= |(inport_word ^ word_prev);
        end
    end

endmodule

// File: tb/tb_inport_conditioner.sv
// Randomised scoreboard bench for inport_conditioner: a tick-counting reference model
// queues the expected outputs per cycle and a monitor compares them against the DUT.
module tb_inport_conditioner;

    localparam int          W   = 16;
    localparam int          TD  = 4;
    localparam int          ST  = 3;
    localparam logic [15:0] INV = 16'h000F;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] raw_in = INV;
    logic [W-1:0] inport_word;
    logic [W-1:0] rise_flags;
    logic [W-1:0] fall_flags;
    logic         change_pulse;

    inport_conditioner #(
        .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .INVERT_MASK(INV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
        .inport_word(inport_word), .rise_flags(rise_flags),
        .fall_flags(fall_flags), .change_pulse(change_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] word;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_changes = 0;
    int   dut_changes = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Reference model: a bit commits on a tick once the run of disagreement it belongs to
    // has spanned ST ticks; ticks fall on cycles n with n mod TD == TD-1 after release.
    initial begin
        logic [W-1:0] hist1, hist2, mword, wprev, nrm;
        int           start [W];
        int           n;
        bit           tk;
        exp_t         e;
        hist1 = INV; hist2 = INV; mword = '0; wprev = '0; n = 0;
        for (int i = 0; i < W; i++) start[i] = -1;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                hist1 = INV; hist2 = INV; mword = '0; wprev = '0; n = 0;
                for (int i = 0; i < W; i++) start[i] = -1;
                q.push_back('0);
            end else begin
                nrm   = hist2 ^ INV;
                hist2 = hist1;
                hist1 = raw_in;
                e.rise = mword & ~wprev;
                e.fall = ~mword & wprev;
                e.chg  = |(mword ^ wprev);
                wprev  = mword;
                tk     = (n % TD) == (TD - 1);
                for (int i = 0; i < W; i++) begin
                    if (nrm[i] == mword[i]) begin
                        start[i] = -1;
                    end else begin
                        if (start[i] < 0) start[i] = n;
                        if (tk && (((n + 1) / TD) - (start[i] / TD)) >= ST) begin
                            mword[i] = nrm[i];
                            start[i] = -1;
                        end
                    end
                end
                e.word = mword;
                if (e.chg) exp_changes++;
                q.push_back(e);
                n++;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                q.delete();
                check("reset_word", inport_word, '0);
                check("reset_rise", rise_flags, '0);
                check("reset_fall", fall_flags, '0);
                check("reset_change", {15'd0, change_pulse}, '0);
            end else if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t: got no expected entry, required one", $time);
            end else begin
                e = q.pop_front();
                if (change_pulse === 1'b1) dut_changes++;
                check("inport_word", inport_word, e.word);
                check("rise_flags", rise_flags, e.rise);
                check("fall_flags", fall_flags, e.fall);
                check("change_pulse", {15'd0, change_pulse}, {15'd0, e.chg});
            end
        end
    end

    task automatic drive(input logic [W-1:0] val, input int cycles);
        @(posedge clk);
        #1 raw_in = val;
        repeat (cycles - 1) @(posedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (cycles - 1) @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] flip;
        raw_in  = INV;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        drive(INV, 100);

        v = INV | 16'h0020;                 drive(v, 30);
        v = v & ~16'h0001;                  drive(v, 30);
        v = v | 16'h0001;                   drive(v, 30);
        drive(v | 16'h0080, 6);             drive(v, 30);
        drive(v | 16'h0080, 14);            drive(v, 30);
        v = (v & ~16'h000C) | 16'h0200;     drive(v, 30);
        v = v | 16'h1000;                   drive(v, 9);
        do_reset(3);
        drive(v, 40);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) flip = W'($urandom);
            else flip = W'(1) << $urandom_range(0, W - 1);
            v = v ^ flip;
            drive(v, $urandom_range(1, 18));
            if (k == 150) do_reset($urandom_range(1, 4));
        end
        drive(v, 40);

        @(negedge clk);
        #1;
        check("change_pulse_count", W'(dut_changes), W'(exp_changes));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
